// File: rtl/lsq_ret_bundle_q.sv
// lsq_ret_bundle_q: in-order retire-bundle queue feeding the LSQ retire-decide stage
module lsq_ret_bundle_q #(
    parameter int DEPTH = 8,
    parameter int SHR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [5:0]       alloc_II,
    input  logic [5:0]       alloc_mask,
    input  logic [23:0]      alloc_slots,
    input  logic             alloc_thread,
    input  logic [SHR_W-1:0] alloc_shr,
    output logic             alloc_full,
    input  logic [5:0]       cmpl_en,
    input  logic [35:0]      cmpl_II,
    input  logic [5:0]       cmpl_excpt,
    input  logic [5:0]       cmpl_ld_confl,
    input  logic [5:0]       cmpl_wait_confl,
    input  logic [23:0]      cmpl_exbits,
    output logic             cmpl_miss,
    input  logic             except,
    input  logic             except_thread,
    output logic             dataB_ready,
    input  logic             dataB_enOut,
    output logic [5:0]       dataB_II,
    output logic [5:0]       dataB_ret_mask,
    output logic [5:0]       dataB_excpt,
    output logic [5:0]       dataB_ld_confl,
    output logic [5:0]       dataB_wait_confl,
    output logic [23:0]      dataB_exbits,
    output logic [3:0]       dataB_II0,
    output logic [3:0]       dataB_II1,
    output logic [3:0]       dataB_II2,
    output logic [3:0]       dataB_II3,
    output logic [3:0]       dataB_II4,
    output logic [3:0]       dataB_II5,
    output logic             dataB_thread,
    output logic [SHR_W-1:0] dataB_data_shr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] thr_q;
    logic [5:0]       ii_q  [DEPTH];
    logic [5:0]       msk_q [DEPTH];
    logic [5:0]       done_q[DEPTH];
    logic [5:0]       exc_q [DEPTH];
    logic [5:0]       ldc_q [DEPTH];
    logic [5:0]       wtc_q [DEPTH];
    logic [23:0]      slt_q [DEPTH];
    logic [23:0]      exb_q [DEPTH];
    logic [SHR_W-1:0] shr_q [DEPTH];

    logic [AW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic [5:0]    hit [DEPTH];
    logic [5:0]    miss;
    logic          do_alloc, do_pop, skip, adv, flush_head;

    always_comb begin
        miss = cmpl_en;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = '0;
            for (int k = 0; k < 6; k++) begin
                hit[i][k] = cmpl_en[k] && vld[i] && ii_q[i] == cmpl_II[6*k +: 6];
                if (hit[i][k]) miss[k] = 1'b0;
            end
        end
    end

    assign alloc_full  = cnt == CW'(DEPTH);
    assign do_alloc    = alloc_en && !alloc_full;
    assign dataB_ready = vld[head] && cnt != '0 && (done_q[head] & msk_q[head]) == msk_q[head];
    // a head flushed this cycle is left as a hole and removed by the skip path next cycle
    assign flush_head  = except && thr_q[head] == except_thread;
    assign do_pop      = dataB_enOut && dataB_ready && !flush_head;
    assign skip        = cnt != '0 && !vld[head];
    assign adv         = do_pop || skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            cmpl_miss <= 1'b0;
            vld       <= '0;
            for (int i = 0; i < DEPTH; i++) done_q[i] <= '0;
        end else begin
            cmpl_miss <= |miss;
            head      <= head + AW'(adv);
            tail      <= tail + AW'(do_alloc);
            cnt       <= cnt + CW'(do_alloc) - CW'(adv);
            for (int i = 0; i < DEPTH; i++) begin
                for (int k = 0; k < 6; k++) begin
                    if (hit[i][k] && msk_q[i][k]) begin
                        done_q[i][k]        <= 1'b1;
                        exc_q[i][k]         <= cmpl_excpt[k];
                        ldc_q[i][k]         <= cmpl_ld_confl[k];
                        wtc_q[i][k]         <= cmpl_wait_confl[k];
                        exb_q[i][4*k +: 4]  <= cmpl_exbits[4*k +: 4];
                    end
                end
                if (except && thr_q[i] == except_thread) vld[i] <= 1'b0;
            end
            if (do_pop) vld[head] <= 1'b0;
            // written last so a same-cycle flush never hits the new entry
            if (do_alloc) begin
                vld[tail]    <= 1'b1;
                ii_q[tail]   <= alloc_II;
                msk_q[tail]  <= alloc_mask;
                slt_q[tail]  <= alloc_slots;
                thr_q[tail]  <= alloc_thread;
                shr_q[tail]  <= alloc_shr;
                done_q[tail] <= '0;
                exc_q[tail]  <= '0;
                ldc_q[tail]  <= '0;
                wtc_q[tail]  <= '0;
                exb_q[tail]  <= '0;
            end
        end
    end

    assign dataB_II         = ii_q[head];
    assign dataB_ret_mask   = msk_q[head];
    assign dataB_excpt      = exc_q[head];
    assign dataB_ld_confl   = ldc_q[head];
    assign dataB_wait_confl = wtc_q[head];
    assign dataB_exbits     = exb_q[head];
    assign dataB_II0        = slt_q[head][3:0];
    assign dataB_II1        = slt_q[head][7:4];
    assign dataB_II2        = slt_q[head][11:8];
    assign dataB_II3        = slt_q[head][15:12];
    assign dataB_II4        = slt_q[head][19:16];
    assign dataB_II5        = slt_q[head][23:20];
    assign dataB_thread     = thr_q[head];
    assign dataB_data_shr   = shr_q[head];
endmodule

// File: doc/lsq_ret_bundle_q.md
Name: lsq_ret_bundle_q

Overview:
- In-order queue of memory-retire bundles on the LSQ side; producer of the dataB_* interface consumed by the LSQ retire-decide stage.
- A bundle is allocated at dispatch with its 6-bit II, lane mask, per-lane slot indices, thread and share payload.
- Per-lane memory completions mark lanes done and record exception/conflict flags.
- The head bundle is presented as dataB_* once every masked lane is done. It is dequeued when the retire stage asserts dataB_enOut.

Parameters:
- DEPTH, 8, number of bundle entries; power of two, 2..32.
- SHR_W, `lsqshare_width, width of the per-bundle share payload.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_en  in  1  allocate a bundle at the tail
- alloc_II  in  6  bundle II
- alloc_mask  in  6  lanes carrying memory ops
- alloc_slots  in  24  4-bit slot index per lane; lane k uses [4k+:4]
- alloc_thread  in  1  thread of the bundle
- alloc_shr  in  SHR_W  share payload
- alloc_full  out  1  queue cannot accept an allocation this cycle
- cmpl_en  in  6  completion valid, one bit per lane
- cmpl_II  in  36  target bundle II per lane; lane k uses [6k+:6]
- cmpl_excpt  in  6  per-lane exception flag
- cmpl_ld_confl  in  6  per-lane load conflict flag
- cmpl_wait_confl  in  6  per-lane wait conflict flag
- cmpl_exbits  in  24  4 exception bits per lane
- cmpl_miss  out  1  pulse: a completion matched no live entry
- except  in  1  flush request
- except_thread  in  1  thread to flush
- dataB_ready  out  1  head bundle complete
- dataB_enOut  in  1  consumer dequeue
- dataB_II  out  6  head bundle II
- dataB_ret_mask  out  6  head lane mask
- dataB_excpt  out  6  head per-lane exception flags
- dataB_ld_confl  out  6  head per-lane load conflict flags
- dataB_wait_confl  out  6  head per-lane wait conflict flags
- dataB_exbits  out  24  head per-lane exception bits
- dataB_II0..dataB_II5  out  4 each  head slot indices
- dataB_thread  out  1  head thread
- dataB_data_shr  out  SHR_W  head share payload

Behaviour:
- Storage per entry: valid, II, mask, slots, thread, shr, done[5:0], excpt, ld_confl, wait_confl and exbits.
- Pointers: head and tail, log2(DEPTH) bits each, wrapping modulo DEPTH. The occupancy counter cnt is 0..DEPTH.
- Reset: all valid and done bits 0; head=tail=cnt=0; cmpl_miss=0.
- alloc_full is cnt==DEPTH and is registered-state only. A pop in the same cycle does not free a slot for an allocation in that cycle.
- Allocation (alloc_en && !alloc_full):
  - Write the tail entry with valid=1, done=0 and flags=0.
  - tail+1, cnt+1.
  - alloc_en while full is ignored.
- Completion, each lane k independently:
  - Match the valid entry with II==cmpl_II[6k+:6].
  - If alloc_mask bit k is set for that entry, set done[k] and capture flags[k] and exbits[4k+:4].
  - If the lane is not in the mask, the completion is ignored without a miss.
  - If no valid entry matches, pulse cmpl_miss in the next cycle.
  - Live IIs are unique; the driver guarantees this.
- Completions are registered. A completion in cycle N can make dataB_ready high in cycle N+1 at the earliest.
- dataB_ready = head valid && cnt!=0 && (done & mask)==mask. A bundle with mask=0 is ready as soon as it is at the head.
- dataB_* outputs are combinational reads of the head entry. When dataB_ready=0 their values are don't-care, except dataB_ready itself.
- Pop (dataB_enOut && dataB_ready): clear head valid, head+1, cnt-1. dataB_enOut without ready is ignored.
- Flush (except): clear valid on every entry whose thread==except_thread.
  - Flush wins over a completion to that entry in the same cycle.
  - Flush wins over a pop of that entry in the same cycle. The entry is removed once, by the skip rule below.
  - An allocation in the flush cycle is not flushed.
- Hole skip: if cnt!=0 and the head entry is invalid, advance head and decrement cnt by one per cycle. A hole is never presented as ready.
- Simultaneous allocation and pop or skip: cnt is unchanged and both pointers advance.
- Reset while busy: the whole queue is emptied in the same cycle and pending inputs are ignored.

Test Plan:
- Reset, then allocate II=5, mask=6'b000011, slots 3/7, then complete lane0 and lane1 for II=5 on separate cycles -> ready=0 after the first completion. dataB_ready=1 one cycle after the second, with dataB_ret_mask=6'b000011, dataB_II0=3, dataB_II1=7. Assert enOut -> queue empty the next cycle.
- Fill DEPTH=8 bundles -> alloc_full=1. A 9th alloc together with a pop -> 9th alloc dropped, cnt=7 the next cycle, alloc_full=0.
- Complete lane2 of II=9 with excpt=1 and exbits=4'hA -> at the head, dataB_excpt=6'b000100 and dataB_exbits[11:8]=4'hA.
- Completion to II=40 with nothing live -> cmpl_miss high for exactly one cycle; no state change.
- Threads interleaved T0,T1,T0 at the head, then except with thread 0 -> the T1 bundle becomes head after one skip cycle. Its completion sets ready; the T0 bundles never appear.
- Wrap: allocate and pop 20 bundles with mask=0 -> each is ready at the head. II order is preserved across pointer wrap.
